// File: rtl/issue_scoreboard.sv
// Per-register pending-write scoreboard beside ID: issue/stall/flush decisions, PC and IF/ID enables, ID/EX bubble, perf counters.
// Zero-cycle latency: every control output is combinational from the inputs and the current scoreboard state.
module issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [4:0]       id_dest,
    input  logic             br_taken,
    input  logic             dmem_wait,
    output logic             stall,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [NREG-1:0]  busy_mask,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LOAD = CW'(DEPTH);

    logic [CW-1:0]    cnt_q [NREG];
    logic [CW-1:0]    cnt_d [NREG];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             br_pend_q, br_pend_d;
    logic             freeze, br_eff, hazard, issue;

    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    // A branch that arrives during a freeze is remembered so it still redirects once the pipe moves.
    assign freeze = dmem_wait;
    assign br_eff = br_taken | br_pend_q;
    assign hazard = id_valid & ((id_use_rs & busy_mask[id_rs]) | (id_use_rt & busy_mask[id_rt]));

    always_comb begin
        stall       = 1'b0;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        issue       = 1'b0;
        if (freeze) begin
            issue = 1'b0;
        end else if (br_eff) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard) begin
            stall       = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            issue   = 1'b1;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!freeze && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
            // A fresh write (including WAW reissue) wins over this edge's decrement.
            if (issue && id_valid && id_wr_en && (id_dest == 5'(r)) && r != 0) begin
                cnt_d[r] = LOAD;
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        br_pend_d = freeze ? (br_pend_q | br_taken) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            br_pend_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            br_pend_q   <= br_pend_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench: driver pushes expected outputs from a remaining-cycles reference model; negedge monitor pops and compares.
module tb_issue_scoreboard;
    localparam int NREG = 32, DEPTH = 3, CNT_W = 16;
    localparam int SAT = 65535;

    logic clk = 1'b0;
    logic reset, id_valid, id_use_rs, id_use_rt, id_wr_en, br_taken, dmem_wait;
    logic [4:0] id_rs, id_rt, id_dest;
    logic stall, pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [NREG-1:0] busy_mask;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    issue_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_dest(id_dest),
        .br_taken(br_taken), .dmem_wait(dmem_wait), .stall(stall), .pc_we(pc_we),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .busy_mask(busy_mask), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct packed {
        logic        stall, pc_we, ifid_we, ifid_flush, idex_bubble;
        logic [31:0] busy;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0, miscompares = 0;

    // Reference model: remaining cycles each register stays pending, plain integer counters.
    int rem [NREG];
    int sc_m = 0, fc_m = 0;
    bit br_late = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit reg_busy(input logic [4:0] r);
        return (r != 0) && (rem[r] > 0);
    endfunction

    function automatic bit m_hazard();
        return id_valid && ((id_use_rs && reg_busy(id_rs)) || (id_use_rt && reg_busy(id_rt)));
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        for (int r = 1; r < NREG; r++) e.busy[r] = (rem[r] > 0);
        e.sc = 16'(sc_m);
        e.fc = 16'(fc_m);
        if (dmem_wait) begin
            e.stall = 0;
        end else if (br_taken || br_late) begin
            e.pc_we = 1; e.ifid_we = 1; e.ifid_flush = 1; e.idex_bubble = 1;
        end else if (m_hazard()) begin
            e.stall = 1; e.idex_bubble = 1;
        end else begin
            e.pc_we = 1; e.ifid_we = 1;
        end
        return e;
    endfunction

    task automatic model_edge();
        bit brx, hz;
        brx = br_taken || br_late;
        hz  = m_hazard();
        if (reset) begin
            for (int r = 0; r < NREG; r++) rem[r] = 0;
            sc_m = 0; fc_m = 0; br_late = 0;
        end else if (dmem_wait) begin
            br_late = br_late || br_taken;
        end else begin
            for (int r = 0; r < NREG; r++) if (rem[r] > 0) rem[r]--;
            if (brx) fc_m = (fc_m < SAT) ? fc_m + 1 : SAT;
            else if (hz) sc_m = (sc_m < SAT) ? sc_m + 1 : SAT;
            else if (id_valid && id_wr_en && id_dest != 0) rem[id_dest] = DEPTH;
            br_late = 0;
        end
    endtask

    task automatic step();
        expq.push_back(model_out());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                          input bit wr, input int dst, input bit br, input bit dm);
        id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
        id_wr_en = wr; id_dest = 5'(dst); br_taken = br; dmem_wait = dm;
    endtask

    task automatic writer(input int d);
        set_in(1, 0, 0, 0, 0, 1, d, 0, 0);
    endtask

    task automatic reader(input int s);
        set_in(1, s, 1, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("stall",        32'(stall),        32'(e.stall));
            chk("pc_we",        32'(pc_we),        32'(e.pc_we));
            chk("ifid_we",      32'(ifid_we),      32'(e.ifid_we));
            chk("ifid_flush",   32'(ifid_flush),   32'(e.ifid_flush));
            chk("idex_bubble",  32'(idex_bubble),  32'(e.idex_bubble));
            chk("busy_mask",    busy_mask,         e.busy);
            chk("stall_cycles", 32'(stall_cycles), 32'(e.sc));
            chk("flush_count",  32'(flush_count),  32'(e.fc));
        end
    end

    initial begin
        int hz_done;
        int guard;
        for (int r = 0; r < NREG; r++) rem[r] = 0;
        reset = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Reset with random inputs held; the model clears at the first edge.
        for (int i = 0; i < 5; i++) begin
            set_in($urandom_range(1), $urandom_range(31), $urandom_range(1), $urandom_range(31),
                   $urandom_range(1), $urandom_range(1), $urandom_range(31), $urandom_range(1),
                   $urandom_range(1));
            step();
        end
        reset = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Writer r3 then dependent reader: three stall cycles, issue in the fourth.
        writer(3); step();
        for (int i = 0; i < 4; i++) begin reader(3); step(); end

        // r0 is never tracked.
        writer(0); step();
        reader(0); step(); step();

        // Reader stalled on r5, taken branch in the second stall cycle kills it.
        writer(5); step();
        reader(5); step();
        set_in(1, 5, 1, 0, 0, 1, 9, 1, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();

        // Freeze in t+2, t+3 stretches r7's busy window; reader issues at t+6.
        writer(7); step();
        reader(7); step();
        set_in(1, 7, 1, 0, 0, 0, 0, 0, 1); step(); step();
        for (int i = 0; i < 3; i++) begin reader(7); step(); end

        // Branch seen while frozen redirects on the first unfrozen cycle.
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();

        // Random traffic over a small register set for frequent hazards.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(199) == 0);
            set_in($urandom_range(3) != 0, $urandom_range(7), $urandom_range(1),
                   $urandom_range(7), $urandom_range(1), $urandom_range(1), $urandom_range(7),
                   $urandom_range(9) == 0, $urandom_range(7) == 0);
            step();
        end
        reset = 0;

        // Saturate stall_cycles: reload r1 then three hazard cycles on it, repeated.
        hz_done = 0;
        while (hz_done < 65540) begin
            writer(1); step();
            for (int i = 0; i < 3; i++) begin reader(1); step(); end
            hz_done += 3;
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        guard = 0;
        while (expq.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
        chk("queue_drain", 32'(expq.size()), 32'd0);
        @(negedge clk);
        chk("stall_sat", 32'(stall_cycles), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Sequential issue-control unit for the 5-stage MIPS pipeline. It replaces per-stage destination comparisons with a per-register pending-write scoreboard and sits beside the ID stage. It decides each cycle whether the ID instruction issues, stalls or is flushed. It also drives the PC and IF/ID write enables, the ID/EX bubble, and two saturating performance counters.

## Interface
Parameters:
- NREG, 32: architectural register count; register 0 is never tracked.
- DEPTH, 3: stages between issue and register-file write completion (EX, MEM, WB).
- CNT_W, 16: performance-counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  5  source register rs of ID instruction.
- id_rt  in  5  source register rt of ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_wr_en  in  1  ID instruction writes a register.
- id_dest  in  5  destination register of ID instruction.
- br_taken  in  1  branch in EX resolved taken (redirect).
- dmem_wait  in  1  data memory not ready; whole pipeline frozen.
- stall  out  1  ID instruction held this cycle (source hazard).
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  load NOP into ID/EX instead of the ID instruction.
- busy_mask  out  NREG  bit r = register r has a pending write.
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of taken-branch flushes.

## Operation
- Scoreboard: one 2-bit down-counter cnt[r] per register. busy_mask[r] = (cnt[r] != 0). cnt[0] is hard-wired to 0.
- freeze = dmem_wait. hazard = id_valid & ((id_use_rs & busy[id_rs]) | (id_use_rt & busy[id_rt])).
- Priority: freeze > br_taken > hazard > issue.
- freeze:
  - pc_we = 0, ifid_we = 0, ifid_flush = 0, idex_bubble = 0, stall = 0.
  - All counters hold and no load occurs.
  - A br_taken seen while frozen is acted on in the first unfrozen cycle.
- br_taken (not frozen):
  - pc_we = 1, ifid_we = 1, ifid_flush = 1, idex_bubble = 1, stall = 0.
  - The ID instruction is killed and no scoreboard load occurs.
  - flush_count increments.
- hazard (not frozen, no branch):
  - stall = 1, pc_we = 0, ifid_we = 0, idex_bubble = 1.
  - stall_cycles increments.
- issue (none of the above):
  - pc_we = 1, ifid_we = 1, idex_bubble = 0.
  - If id_valid & id_wr_en & id_dest != 0, cnt[id_dest] loads DEPTH.
- Every unfrozen edge decrements each nonzero counter. The load for id_dest takes precedence over that register's decrement.
- WAW: reissuing a write to a pending register reloads it to DEPTH. There is no stall on the destination alone.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset state: all cnt = 0, stall_cycles = 0, flush_count = 0.
- Outputs after reset: busy_mask = 0, stall = 0, pc_we = 1, ifid_we = 1, ifid_flush = 0, idex_bubble = 0 (given dmem_wait = 0, br_taken = 0).
- Reset mid-operation clears all pending state on the next edge.
- All control outputs are combinational from the inputs and current scoreboard state. Zero-cycle latency.
- A writer issued in cycle t:
  - Is busy during t+1..t+DEPTH.
  - A dependent instruction in ID stalls in cycles t+1..t+DEPTH and issues in t+DEPTH+1.
  - No write-through bypass of the register file is assumed.
- Each frozen cycle extends the remaining busy window by one cycle.

## Test plan
- Reset with random inputs held, then release with dmem_wait = 0 -> busy_mask = 0, stall = 0, pc_we = 1, both counters = 0.
- Issue writer to r3 at cycle 10, then reader of r3 in ID -> stall = 1 in cycles 11–13, reader issues in cycle 14, stall_cycles = 3, busy_mask[3] clears after cycle 13.
- Issue writer to r0, then reader of r0 -> never stalls, busy_mask stays 0.
- Reader stalled on r5; assert br_taken in the second stall cycle -> ifid_flush = 1, idex_bubble = 1, stall = 0, flush_count = 1, and the killed instruction's id_dest stays not busy.
- Writer to r7 issued at t, dmem_wait = 1 in cycles t+2 and t+3 -> cnt[7] holds, reader of r7 issues at t+6, pc_we = 0 during the freeze.
- Force 65540 hazard cycles -> stall_cycles saturates at 0xFFFF.
